// File: rtl/data_memory_sync.sv
// rtl/data_memory_sync.sv - clocked data memory with registered read, init sweep and range check
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - synchronous active-low reset
//   rd, wr    - read / write request, sampled at the edge while ready=1
//   abus      - word address
//   in_dbus   - write data
//   out_dbus  - registered read data
//   rd_valid  - one-cycle strobe, out_dbus holds the previous accepted read
//   ready     - high once the init sweep has filled every word
//   addr_err  - one-cycle strobe, accepted rd/wr addressed a word >= DEPTH

module data_memory_sync #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 32,
  parameter int INIT_WORDS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] abus,
  input  logic [DATA_W-1:0] in_dbus,
  output logic [DATA_W-1:0] out_dbus,
  output logic              rd_valid,
  output logic              ready,
  output logic              addr_err
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] INIT_WORDS_W = (ADDR_W+1)'(INIT_WORDS);
  localparam logic [ADDR_W:0] LAST_W       = (ADDR_W+1)'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] out_dbus_q;
  logic              rd_valid_q;
  logic              ready_q;
  logic              addr_err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_range_d;
  logic [ADDR_W:0]   cnt_inc_d;
  logic [DATA_W-1:0] init_val_d;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    in_range_d = ({1'b0, abus} < DEPTH_W);
    cnt_inc_d  = cnt_q + 1'b1;
    // Words below INIT_WORDS get address+1 (truncated), the rest start at 0.
    init_val_d = (cnt_q < INIT_WORDS_W) ? DATA_W'(cnt_inc_d) : '0;
    // Write-first: a same-edge write to the read address forwards the new data.
    rd_data_d  = '0;
    if (in_range_d) begin
      rd_data_d = wr ? in_dbus : mem_q[abus];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      out_dbus_q <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          mem_q[cnt_q[ADDR_W-1:0]] <= init_val_d;
          cnt_q                    <= cnt_inc_d;
          rd_valid_q               <= 1'b0;
          addr_err_q               <= 1'b0;
          if (cnt_q == LAST_W) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (wr && in_range_d) begin
            mem_q[abus] <= in_dbus;
          end
          if (rd) begin
            out_dbus_q <= rd_data_d;
          end
          rd_valid_q <= rd;
          addr_err_q <= (rd || wr) && !in_range_d;
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_dbus = out_dbus_q;
  assign rd_valid = rd_valid_q;
  assign ready    = ready_q;
  assign addr_err = addr_err_q;

endmodule

// File: doc/data_memory_sync.md
# data_memory_sync

Clocked, parametrised data memory for the single-cycle processor datapath. It is the successor to the current 32x8 latch-style data memory. It adds:
- a synchronous registered read port with a valid strobe,
- defined read-during-write behaviour,
- out-of-range address detection,
- a hardware initialisation sequencer that reloads the power-on contents after every reset.

It sits between the ALU address output and the register-file write-back mux.

## Interface
Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 5, address bus width
- DEPTH, 32, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W
- INIT_WORDS, 5, words 0..INIT_WORDS-1 are initialised to address+1; all others to 0; must satisfy INIT_WORDS <= DEPTH

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- rd  in  1  read request, sampled on the clock edge
- wr  in  1  write request, sampled on the clock edge
- abus  in  ADDR_W  word address
- in_dbus  in  DATA_W  write data
- out_dbus  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe: out_dbus holds the result of the rd accepted on the previous edge
- ready  out  1  high when the block accepts rd/wr
- addr_err  out  1  one-cycle strobe: the accepted rd or wr targeted abus >= DEPTH

## Operation
- State machine with two states: INIT and RUN.
- Reset: rst_n low at an edge forces state INIT, the init counter to 0, and out_dbus, rd_valid, ready and addr_err all to 0. Reset wins over every other input, including mid-INIT and mid-RUN.
- INIT:
  - Each cycle with rst_n high, write the init value to mem[counter], then increment the counter.
  - Init value is counter+1, truncated to DATA_W, for counter < INIT_WORDS; otherwise 0.
  - After writing word DEPTH-1, go to RUN.
  - rd and wr are ignored; rd_valid and addr_err stay 0.
- RUN: ready=1; a request is accepted when ready=1 at the edge.
- Write: wr=1 and abus < DEPTH → mem[abus] <= in_dbus.
- Read: rd=1 and abus < DEPTH → out_dbus <= mem[abus]; rd_valid <= 1.
- Read and write to the same address in the same edge: write-first, so out_dbus returns the new in_dbus.
- Out of range (abus >= DEPTH):
  - Any write is dropped.
  - A read loads out_dbus with 0 and still pulses rd_valid.
  - addr_err <= 1 if rd or wr was asserted.
- Idle cycle (rd=0): out_dbus holds its last value; rd_valid <= 0.
- addr_err <= 0 on every edge without an out-of-range access.
- Memory contents are not cleared by anything other than the INIT sweep.

## Timing
- Read latency is 1 cycle: request at edge N gives out_dbus and rd_valid valid after edge N, sampled at edge N+1.
- Write latency is 1 edge; a read at edge N+1 sees data written at edge N.
- Full throughput: one rd and/or one wr accepted every cycle in RUN.
- INIT duration:
  - ready rises after exactly DEPTH rising edges with rst_n high following the last reset edge.
  - The reset edge itself does not count toward DEPTH.
  - Default configuration: ready=1 after the 32nd such edge.
- Reset asserted mid-INIT restarts the sweep from address 0.
- Reset asserted mid-read: the pending rd_valid is suppressed (0 after the reset edge).
- Requests presented while ready=0 are lost; the requester must hold them until ready=1.

## Test plan
- Reset/INIT:
  - Stimulus: rst_n low 2 cycles, then high.
  - Required: ready=0 for 32 cycles, then 1.
  - Then read addresses 0..5 → 0x01, 0x02, 0x03, 0x04, 0x05, 0x00, each with rd_valid one cycle after the request.
- Back-to-back writes and reads:
  - Stimulus: write 0xA5 to addr 7 and 0x3C to addr 31 on consecutive cycles; then rd 7, rd 31 on consecutive cycles.
  - Required: out_dbus = 0xA5 then 0x3C; rd_valid high for 2 consecutive cycles.
- Read-during-write:
  - Stimulus: same edge rd=1, wr=1, abus=4, in_dbus=0x99.
  - Required: next cycle out_dbus=0x99, rd_valid=1; a later read of addr 4 also gives 0x99.
- Out of range (DEPTH=20, ADDR_W=5):
  - Stimulus: write 0x55 to addr 25.
  - Required: addr_err pulses for one cycle.
  - Then rd 25 → out_dbus=0x00, rd_valid=1, addr_err=1; mem[25 mod 20 = 5] unchanged.
- Reset mid-operation:
  - Stimulus: after writing 0xEE to addr 2, assert rst_n low mid-INIT sweep at counter=10, then release.
  - Required: the full 32-cycle INIT reruns; addr 2 reads back 0x03.
- Width scaling (DATA_W=16, INIT_WORDS=0):
  - Required: all words read 0x0000 after INIT.
  - Write 0xBEEF to addr 0 → reads back 0xBEEF.
